// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, ExcCodes, vector.
package cp0_pkg;

    localparam logic [4:0]  CP0_SR    = 5'd12;
    localparam logic [4:0]  CP0_CAUSE = 5'd13;
    localparam logic [4:0]  CP0_EPC   = 5'd14;

    // SR field positions
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;
    localparam int SR_EXL    = 1;
    localparam int SR_IE     = 0;

    // Cause field positions
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_EC_LO = 2;
    localparam int CAUSE_EC_HI = 6;

    // ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] CP0_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 exception/interrupt controller: holds SR, Cause, EPC beside the M stage
// and raises req when an enabled interrupt or a synchronous exception is due.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VECTOR = CP0_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        req
);

    // SR
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    // Cause
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    // EPC
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [4:0]  w_exc_sel;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // The vector is consumed by the PC logic; kept here only for reference.
    logic        w_unused_vector;
    assign w_unused_vector = ^VECTOR;

    // Request terms: EXL masks both, so only one request per handler window.
    assign w_int_req  = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req  = (exc_code_in != 5'd0) & ~r_sr_exl;
    assign req        = w_int_req | w_exc_req;
    assign w_exc_sel  = w_int_req ? EXC_INT : exc_code_in;
    assign w_epc_next = bd_in ? (vpc - 32'd4) : vpc;

    assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};
    assign epc_out = r_epc;

    // Combinational mfc0 read of the registered values.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            CP0_SR:    rdata = w_sr;
            CP0_CAUSE: rdata = w_cause;
            CP0_EPC:   rdata = r_epc;
            default:   rdata = 32'd0;
        endcase
    end

    // Register update: reset beats req, req beats mtc0/eret, eret beats mtc0 on EXL.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 32'd0;
        end else begin
            r_cause_ip <= hw_int;
            if (req) begin
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bd_in;
                r_cause_exc <= w_exc_sel;
                r_epc       <= w_epc_next;
            end else begin
                if (we && addr == CP0_SR) begin
                    r_sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
                    r_sr_exl <= wdata[SR_EXL];
                    r_sr_ie  <= wdata[SR_IE];
                end
                if (we && addr == CP0_EPC)
                    r_epc <= wdata;
                if (eret)
                    r_sr_exl <= 1'b0;
            end
        end
    end

endmodule
